serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial subtractor: diff = a - b - bin, computed LSB-first, one bit per clock.
//  It is the inverse-direction counterpart to the ripple adder in the ALU group.
//  Valid/ready handshake on both sides; sits beside the combinational adder in the ALU datapath.
// PARAMETERS
//  WIDTH   4   operand/result width in bits (>=2)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow out (1 when a < b + bin, unsigned)
//  ovf        out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; diff=0; bout=0; ovf=0; counter=0.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid & in_ready at edge k: latch a, b; load bin into the borrow flop; clear the counter; go to SHIFT.
//  SHIFT:
//   - in_ready=0; in_valid is ignored.
//   - Each edge: d = a_sh[0]^b_sh[0]^br; br' = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br).
//   - d shifts into diff MSB; a_sh/b_sh shift right; counter++.
//   - After WIDTH edges (edge k+WIDTH): bout=br', go to DONE.
//  DONE:
//   - out_valid=1; diff/bout/ovf held stable until out_ready.
//   - On out_valid & out_ready: go to IDLE; out_valid=0 next cycle.
//   - diff/bout keep their last value until the next accept.
//  Latency: out_valid is first high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after accept.
//  No overlap: in_ready is 0 in SHIFT and DONE, so throughput is 1 op per WIDTH+2 cycles minimum.
//  Counter: $clog2(WIDTH+1) bits; no wrap occurs (reset to 0 on every accept).
//  Boundary cases:
//   - a=b, bin=0 -> diff=0, bout=0.
//   - bin=1 with a=b -> all ones, bout=1.
//   - Reset mid-SHIFT or mid-DONE aborts the operation; no result is produced.
//   - out_ready held high in IDLE or SHIFT has no effect.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//   - ovf port present.
//   - ovf = (a[W-1]!=b[W-1]) & (diff[W-1]!=a[W-1]), registered at the end of SHIFT.
//   - Valid and held with out_valid.
//  Not defined: ovf port and its logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package alu_pkg:
//   - FSM state encoding constants (ST_IDLE, ST_SHIFT, ST_DONE).
//   - Default width constant ALU_W=4.
//  One sub-module: full_subtractor (1-bit: a, b, bin -> d, bout, combinational), instantiated once.
//  Top level holds the FSM, shift registers, borrow flop and counter.
// TESTING (WIDTH=4)
//  1. a=0101 b=0011 bin=0 -> diff=0010 bout=0, out_valid 5 cycles after accept.
//  2. a=0000 b=0001 bin=0 -> diff=1111 bout=1; a=0000 b=1111 bin=1 -> diff=0000 bout=1.
//  3. a=1010 b=0101 bin=1 -> diff=0100 bout=0; with OVF_EN: a=1000 b=0001 -> diff=0111 ovf=1.
//  4. Backpressure:
//     - Hold out_ready=0 for 6 cycles in DONE -> diff/bout stable, in_ready=0.
//     - in_valid pulses in that window are ignored.
//  5. Assert rst at the 2nd SHIFT cycle -> immediately out_valid=0, in_ready=1, diff=0.
//     - Next op a=1100 b=0011 -> diff=1001 bout=0.
//  6. Exhaustive sweep of all 512 (a,b,bin) combos vs a golden model, back-to-back with out_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU datapath group.
//   ST_IDLE / ST_SHIFT / ST_DONE : serial-unit FSM state encoding
//   ALU_W                        : default operand width
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor: d = a - b - bin.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d         : difference bit
//   bout      : borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor, LSB first, one bit per clock: diff = a - b - bin.
// Operands are taken on an in_valid/in_ready handshake, the result is
// presented on out_valid/out_ready. No overlap between operations.
// Optional macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid, in_ready  : operand handshake
//   a, b, bin           : minuend, subtrahend, borrow in
//   out_valid, out_ready: result handshake
//   diff, bout          : difference (mod 2^WIDTH) and unsigned borrow out
//   ovf                 : signed overflow (SERIAL_SUB_OVF_EN only)
// ---------------------------------------------------------------------------
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             br_next;
  logic             accept;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid & in_ready;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  // Control, borrow chain and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      br        <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            br    <= bin;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          diff <= {d_bit, diff[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            bout      <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit a_sh[0]/b_sh[0] are the operand sign bits and
            // d_bit is the result sign bit.
            ovf       <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
`endif
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand shift registers: pure data, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == ST_SHIFT) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Directed test bench for serial_subtractor at WIDTH=4.
// Define SERIAL_SUB_OVF_EN to also cover the ovf output.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total;
  int bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
    .bout      (bout),
    .ovf       (ovf)
`else
    .bout      (bout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands at a negedge, wait for accept, then count negedges
  // until out_valid (lat = cycles after accept).
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic rdy, output int lat);
    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Check result, complete the output handshake, confirm return to IDLE.
  task automatic finish_op(input string tag, input logic [W-1:0] ediff,
                           input logic ebout);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_diff"}, diff, ediff);
    chk({tag, "_bout"}, bout, ebout);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ovld_clr"}, out_valid, 0);
    chk({tag, "_irdy_set"}, in_ready, 1);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input logic tbin,
                          input logic [W-1:0] ediff, input logic ebout);
    int lat;
    start_op(ta, tb, tbin, 1'b1, lat);
    chk({tag, "_lat"}, lat, W + 1);
    finish_op(tag, ediff, ebout);
  endtask

  initial begin
    int lat;
    logic [W-1:0] hd;
    logic hb;
    logic [W:0] gold;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic vbin;
    total = 0;
    bad = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    directed("t1", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0);
    directed("t2a", 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1);
    directed("t2b", 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1);
    directed("t3", 4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0);
    directed("eq0", 4'b0110, 4'b0110, 1'b0, 4'b0000, 1'b0);
    directed("eq1", 4'b1001, 4'b1001, 1'b1, 4'b1111, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
    start_op(4'b1000, 4'b0001, 1'b0, 1'b1, lat);
    chk("ovf1", ovf, 1);
    finish_op("t3ovf", 4'b0111, 1'b0);
    start_op(4'b0011, 4'b0001, 1'b0, 1'b1, lat);
    chk("ovf0", ovf, 0);
    finish_op("t3novf", 4'b0010, 1'b0);
`endif

    // Backpressure: hold result for 6 cycles with stray in_valid pulses
    start_op(4'b1110, 4'b0100, 1'b0, 1'b0, lat);
    chk("bp_lat", lat, W + 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      a = 4'(i); b = 4'(15 - i); bin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_diff", diff, 4'b1010);
      chk("bp_bout", bout, 0);
    end
    in_valid = 1'b0;
    finish_op("bp", 4'b1010, 1'b0);
    chk("bp_diff_kept", diff, 4'b1010);

    // Reset during the second SHIFT cycle
    a = 4'b0111; b = 4'b0010; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ovld", out_valid, 0);
    chk("mid_rst_irdy", in_ready, 1);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ovld", out_valid, 0);
    directed("t5", 4'b1100, 4'b0011, 1'b0, 4'b1001, 1'b0);

    // Exhaustive sweep against a golden model
    for (int k = 0; k < 512; k++) begin
      va = k[3:0];
      vb = k[7:4];
      vbin = k[8];
      gold = {1'b0, va} - {1'b0, vb} - {4'b0, vbin};
      hd = gold[W-1:0];
      hb = gold[W];
      start_op(va, vb, vbin, 1'b1, lat);
      chk("sw_lat", lat, W + 1);
      chk("sw_diff", diff, hd);
      chk("sw_bout", bout, hb);
`ifdef SERIAL_SUB_OVF_EN
      chk("sw_ovf", ovf, (va[W-1] != vb[W-1]) && (hd[W-1] != va[W-1]));
`endif
      @(posedge clk);
      @(negedge clk);
      chk("sw_ovld_clr", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
